serial_match_scheduler: RTL and testbench
=========================================

SERIAL_MATCH_SCHEDULER -- requirements
Module: serial_match_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (2..8).
REQ-002 Parameter PATTERN, default 4'b0111: 4-bit match pattern, MSB received first.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester request; held high with data until grant.
REQ-006 data_in  input  8*NREQ  per-requester byte; requester k occupies bits [8k+7:8k].
REQ-007 gnt  output  NREQ  one-hot, one-cycle grant pulse; the byte is consumed.
REQ-008 busy  output  1  high in SHIFT and REPORT.
REQ-009 done  output  1  one-cycle result strobe.
REQ-010 done_id  output  3  index of the requester whose result is on done.
REQ-011 match_count  output  4  pattern hits in the granted byte; valid when done=1.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and REPORT.
REQ-013 IDLE: on an edge with req!=0, SHALL select the round-robin winner, starting the search at last_id+1 and wrapping modulo NREQ.
REQ-014 On that edge it SHALL latch the winner's byte into an 8-bit shift register, clear bit_cnt, match_count and detector history, set cur_id, and go to SHIFT.
REQ-015 gnt[cur_id] SHALL be high only in the first SHIFT cycle; the requester may drop req or change data from the next cycle.
REQ-016 SHIFT: each cycle SHALL feed shreg[7] to the detector, shift left by 1, and increment bit_cnt.
REQ-017 SHIFT: after the 8th bit (bit_cnt==7) the FSM SHALL go to REPORT.
REQ-018 The detector SHALL be Mealy: hit=1 in the cycle the current bit completes PATTERN over the last 4 bits of the current byte.
REQ-019 The detector SHALL allow overlapping matches and SHALL report no hit before the 4th bit of a byte; no history carries across bytes.
REQ-020 match_count SHALL increment by 1 on each hit; its 4-bit width cannot overflow (at most 5 hits per byte).
REQ-021 REPORT (one cycle): done=1, done_id=cur_id, match_count stable; last_id<=cur_id; next state IDLE.
REQ-022 Timing: grant pulse in cycle T, done in cycle T+8; back-to-back service of one requester every 10 cycles.
REQ-023 req changes during SHIFT/REPORT SHALL be ignored; arbitration occurs only in IDLE.
REQ-024 A requester whose req is low at the IDLE sampling edge SHALL NOT be granted, whatever its position relative to the pointer.

Reset
REQ-025 Reset SHALL force state=IDLE, gnt=0, busy=0, done=0, done_id=0, match_count=0, shreg=0, bit_cnt=0, last_id=NREQ-1 (requester 0 wins first).
REQ-026 Reset during SHIFT or REPORT SHALL abort the byte with no done pulse; the aborted requester is not re-granted automatically.

Configuration
REQ-027 With SMS_HIT_MASK_EN defined: an extra output hit_mask[7:0] SHALL have bit i set when the i-th shifted bit (i=0 first) produced a hit; cleared at grant; valid with done.
REQ-028 Without SMS_HIT_MASK_EN: no hit_mask port or register SHALL exist; all other behaviour is identical.

Structure
REQ-029 Package sms_pkg SHALL hold the state enum (IDLE, SHIFT, REPORT), DATA_W=8 and PAT_LEN=4.
REQ-030 Sub-module pattern_window_detector SHALL contain the 4-bit history register, bits-seen counter, clear input and combinational hit output.

Verification
REQ-031 Single req[0], data 8'b0111_0111: gnt[0] at T, done at T+8 with done_id=0, match_count=2, hit_mask=8'b1000_1000.
REQ-032 req[1] with 8'b0000_0000, then 8'b1110_0000: both counts are 0 (no cross-byte match); the second grant comes exactly 10 cycles after the first.
REQ-033 req=4'b1111 held with fresh data: grant order is 0,1,2,3,0; done_id follows the same order.
REQ-034 Reset asserted at bit_cnt=4 of a 8'b0111_1111 transfer: no done; all outputs return to reset values; the next grant goes to requester 0.
REQ-035 PATTERN=4'b1111, data 8'b1111_1111: match_count=5 and hit_mask=8'b1111_1000.

Source files
------------

// File: rtl/sms_pkg.sv
// Shared types and constants for the serial match scheduler.
// The optional per-bit hit mask output is enabled with SMS_HIT_MASK_EN.
package sms_pkg;

    localparam int DATA_W  = 8;  // width of one requester byte
    localparam int PAT_LEN = 4;  // length of the serial match pattern
    localparam int MAX_REQ = 8;  // largest supported requester count
    localparam int ID_W    = 3;  // width of a requester index
    localparam int CNT_W   = 4;  // width of the per-byte hit counter
    localparam int BIT_W   = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_e;

    // Advance a requester index by one, wrapping at n.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id, input int n);
        if (int'(id) >= n - 1) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

endpackage

// File: rtl/pattern_window_detector.sv
// Mealy serial pattern detector over a sliding window of PAT_LEN bits.
// History and bits-seen count are cleared at the start of every byte so
// no match can span two bytes; hit_o is only possible once PAT_LEN-1 bits
// of the current byte have already been seen.
module pattern_window_detector
    import sms_pkg::*;
#(
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b0111
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    input  logic bit_i,
    output logic hit_o
);

    localparam int                SEEN_W    = $clog2(PAT_LEN);
    localparam logic [SEEN_W-1:0] SEEN_FULL = SEEN_W'(PAT_LEN - 1);

    // The PAT_LEN-1 previous bits; with the incoming bit they form the window.
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [SEEN_W-1:0]  seen_q, seen_d;

    // Window update and combinational (Mealy) hit on the incoming bit.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        hist_d = hist_q;
        seen_d = seen_q;
        hit_o  = 1'b0;
        if (clear_i) begin
            hist_d = '0;
            seen_d = '0;
        end else if (en_i) begin
            hit_o  = (seen_q == SEEN_FULL) && ({hist_q, bit_i} == PATTERN);
            hist_d = {hist_q[PAT_LEN-3:0], bit_i};
            if (seen_q != SEEN_FULL) begin
                seen_d = seen_q + 1'b1;
            end
        end
    end

    // History and bits-seen registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            seen_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            hist_q <= hist_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/serial_match_scheduler.sv
// Round-robin scheduler that grants one requester's byte, shifts it out
// MSB first through a serial pattern detector and reports the hit count.
// Defining SMS_HIT_MASK_EN adds the hit_mask output (bit i = i-th shifted
// bit completed the pattern).
module serial_match_scheduler
    import sms_pkg::*;
#(
    parameter int                 NREQ    = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b0111
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [DATA_W*NREQ-1:0]   data_in,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic [CNT_W-1:0]         match_count
`ifdef SMS_HIT_MASK_EN
    ,
    output logic [DATA_W-1:0]        hit_mask
`endif
);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [ID_W-1:0]     cur_id_q, cur_id_d;
    logic [ID_W-1:0]     last_id_q, last_id_d;
    logic [CNT_W-1:0]    match_count_q, match_count_d;
`ifdef SMS_HIT_MASK_EN
    logic [DATA_W-1:0]   hit_mask_q, hit_mask_d;
`endif

    logic [MAX_REQ-1:0]  req_ext;
    logic [ID_W-1:0]     idx;
    logic [ID_W-1:0]     win_id;
    logic                win_valid;
    logic [DATA_W-1:0]   win_byte;
    logic                det_clear;
    logic                det_en;
    logic                hit;

    pattern_window_detector #(
        .PATTERN (PATTERN)
    ) u_detector (
        .clock   (clock),
        .reset   (reset),
        .clear_i (det_clear),
        .en_i    (det_en),
        .bit_i   (shreg_q[DATA_W-1]),
        .hit_o   (hit)
    );

    // Round-robin search starting one past the last served requester.
    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req;
        idx                = last_id_q;
        win_valid          = 1'b0;
        win_id             = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = wrap_inc(idx, NREQ);
            if (!win_valid && req_ext[idx]) begin
                win_valid = 1'b1;
                win_id    = idx;
            end
        end
    end

    // Pick the winning requester's byte out of the flat data bus.
    always_comb begin
        win_byte = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_id == ID_W'(k)) begin
                win_byte = data_in[DATA_W*k +: DATA_W];
            end
        end
    end

    // Next-state and datapath control; arbitration only happens in IDLE.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        cur_id_d      = cur_id_q;
        last_id_d     = last_id_q;
        match_count_d = match_count_q;
`ifdef SMS_HIT_MASK_EN
        hit_mask_d    = hit_mask_q;
`endif
        det_clear     = 1'b0;
        det_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d       = SHIFT;
                    shreg_d       = win_byte;
                    bit_cnt_d     = '0;
                    match_count_d = '0;
                    cur_id_d      = win_id;
                    det_clear     = 1'b1;
`ifdef SMS_HIT_MASK_EN
                    hit_mask_d    = '0;
`endif
                end
            end
            SHIFT: begin
                det_en    = 1'b1;
                shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (hit) begin
                    match_count_d = match_count_q + 1'b1;
`ifdef SMS_HIT_MASK_EN
                    hit_mask_d[bit_cnt_q] = 1'b1;
`endif
                end
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                last_id_d = cur_id_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: grant pulses only in the first SHIFT cycle.
    always_comb begin
        gnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            gnt[k] = (state_q == SHIFT) && (bit_cnt_q == '0) && (cur_id_q == ID_W'(k));
        end
        busy        = (state_q != IDLE);
        done        = (state_q == REPORT);
        done_id     = done ? cur_id_q : '0;
        match_count = match_count_q;
`ifdef SMS_HIT_MASK_EN
        hit_mask    = hit_mask_q;
`endif
    end

    // State and datapath registers; reset points the arbiter at requester 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            cur_id_q      <= '0;
            last_id_q     <= ID_W'(NREQ - 1);
            match_count_q <= '0;
`ifdef SMS_HIT_MASK_EN
            hit_mask_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            cur_id_q      <= cur_id_d;
            last_id_q     <= last_id_d;
            match_count_q <= match_count_d;
`ifdef SMS_HIT_MASK_EN
            hit_mask_q    <= hit_mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_match_scheduler.sv
// Self-checking bench for serial_match_scheduler: a cycle-level reference
// model predicts grants and byte results; a negedge monitor compares them.
// Build with SMS_HIT_MASK_EN defined to also check the hit_mask output.
module tb_serial_match_scheduler;

    localparam int         NREQ   = 4;
    localparam logic [3:0] PAT    = 4'b0111;
    localparam int         BUDGET = 60;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [8*NREQ-1:0]   data_in = '0;
    logic [NREQ-1:0]     gnt;
    logic                busy, done;
    logic [2:0]          done_id;
    logic [3:0]          match_count;

    logic [NREQ-1:0]     req_p = '0;
    logic [8*NREQ-1:0]   data_p = '0;
    logic [NREQ-1:0]     gnt_p;
    logic                busy_p, done_p;
    logic [2:0]          done_id_p;
    logic [3:0]          mc_p;
`ifdef SMS_HIT_MASK_EN
    logic [7:0]          hit_mask, hit_mask_p;
`endif

    serial_match_scheduler #(.NREQ(NREQ), .PATTERN(PAT)) dut (
        .clock(clock), .reset(reset), .req(req), .data_in(data_in),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
        .match_count(match_count)
`ifdef SMS_HIT_MASK_EN
        , .hit_mask(hit_mask)
`endif
    );

    serial_match_scheduler #(.NREQ(NREQ), .PATTERN(4'b1111)) dut_p (
        .clock(clock), .reset(reset), .req(req_p), .data_in(data_p),
        .gnt(gnt_p), .busy(busy_p), .done(done_p), .done_id(done_id_p),
        .match_count(mc_p)
`ifdef SMS_HIT_MASK_EN
        , .hit_mask(hit_mask_p)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: hits of a byte shifted MSB first, window = 4 consecutive bits.
    function automatic void ref_byte(input logic [7:0] d, input logic [3:0] pat,
                                     output logic [3:0] cnt, output logic [7:0] mask);
        logic [7:0] sh;
        cnt  = '0;
        mask = '0;
        for (int i = 3; i < 8; i++) begin
            sh = d >> (7 - i);
            if (sh[3:0] == pat) begin
                cnt++;
                mask[i] = 1'b1;
            end
        end
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int off = 1; off <= NREQ; off++) begin
            int k;
            k = (last + off) % NREQ;
            if (r[k]) return k;
        end
        return 0;
    endfunction

    typedef struct {
        int         id;
        logic [3:0] cnt;
        logic [7:0] mask;
        int         due;
    } exp_t;

    exp_t sb_q[$];
    int   gnt_id_log[$];
    int   gnt_cyc_log[$];
    int   done_id_log[$];
    int   done_cnt_log[$];
    int   done_cyc_log[$];

    int                cyc = 0;
    int                busy_left = 0;
    int                model_last = NREQ - 1;
    logic [NREQ-1:0]   p_req = '0;
    logic [8*NREQ-1:0] p_data = '0;
    logic              p_rst = 1'b1;

    // Monitor: model predicts at negedge from inputs seen one cycle earlier.
    always @(negedge clock) begin
        logic [NREQ-1:0] exp_gnt;
        logic [3:0]      c;
        logic [7:0]      m;
        int              w;
        exp_t            e;
        cyc++;
        if (reset) begin
            check("rst_gnt", gnt, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_done_id", done_id, 0);
            check("rst_match_count", match_count, 0);
`ifdef SMS_HIT_MASK_EN
            check("rst_hit_mask", hit_mask, 0);
`endif
            sb_q.delete();
            busy_left  = 0;
            model_last = NREQ - 1;
        end else begin
            exp_gnt = '0;
            if (busy_left > 0) begin
                busy_left--;
            end else if (!p_rst && p_req != '0) begin
                w = rr_pick(p_req, model_last);
                exp_gnt[w] = 1'b1;
                ref_byte(p_data[8*w +: 8], PAT, c, m);
                sb_q.push_back('{id: w, cnt: c, mask: m, due: cyc + 8});
                model_last = w;
                busy_left  = 9;
            end
            check("gnt", gnt, exp_gnt);
            check("busy", busy, busy_left > 0);
            for (int k = 0; k < NREQ; k++) begin
                if (gnt[k]) begin
                    gnt_id_log.push_back(k);
                    gnt_cyc_log.push_back(cyc);
                end
            end
            if (done) begin
                done_id_log.push_back(done_id);
                done_cnt_log.push_back(match_count);
                done_cyc_log.push_back(cyc);
                if (sb_q.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_cycle", cyc, e.due);
                    check("done_id", done_id, e.id);
                    check("match_count", match_count, e.cnt);
`ifdef SMS_HIT_MASK_EN
                    check("hit_mask", hit_mask, e.mask);
`endif
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                check("done_missing", done, 1);
                void'(sb_q.pop_front());
            end
        end
        p_req  = req;
        p_data = data_in;
        p_rst  = reset;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_gnt(input int k, input string name);
        int t;
        t = 0;
        while (!gnt[k] && t < BUDGET) begin
            tick();
            t++;
        end
        check(name, gnt[k], 1);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((busy || sb_q.size() != 0) && t < BUDGET) begin
            tick();
            t++;
        end
        check(name, {busy, sb_q.size() != 0}, 0);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] tbl [6];
        tbl = '{8'h77, 8'h7F, 8'hF7, 8'h37, 8'hE7, 8'h0E};
        if ($urandom_range(2) == 0) return tbl[$urandom_range(5)];
        return 8'($urandom);
    endfunction

    initial begin
        logic [NREQ-1:0] last_g;
        int ng, t, g0, d0;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Round-robin with all requesters held: 0,1,2,3,0.
        for (int k = 0; k < NREQ; k++) data_in[8*k +: 8] = rand_byte();
        req    = '1;
        ng     = 0;
        t      = 0;
        last_g = '0;
        while (ng < 5 && t < BUDGET * 6) begin
            tick();
            t++;
            for (int k = 0; k < NREQ; k++)
                if (last_g[k]) data_in[8*k +: 8] = rand_byte();
            last_g = gnt;
            if (gnt != '0) ng++;
        end
        check("rr_grant_budget", ng, 5);
        tick();
        req = '0;
        wait_idle("rr_idle");
        check("rr_log_len", gnt_id_log.size(), 5);
        for (int i = 0; i < 5 && i < gnt_id_log.size(); i++) begin
            check("rr_gnt_order", gnt_id_log[i], exp_order[i]);
            if (i < done_id_log.size()) check("rr_done_order", done_id_log[i], exp_order[i]);
        end

        // Single requester 0 with 0111_0111.
        g0 = gnt_cyc_log.size();
        d0 = done_cyc_log.size();
        data_in = '0;
        data_in[7:0] = 8'b0111_0111;
        req = 4'b0001;
        wait_gnt(0, "t031_gnt");
        tick();
        req = '0;
        wait_idle("t031_idle");
        check("t031_done_seen", done_cyc_log.size(), d0 + 1);
        if (done_cyc_log.size() > d0 && gnt_cyc_log.size() > g0) begin
            check("t031_latency", done_cyc_log[d0] - gnt_cyc_log[g0], 8);
            check("t031_id", done_id_log[d0], 0);
            check("t031_count", done_cnt_log[d0], 2);
        end

        // Requester 1: 0000_0000 then 1110_0000 held back-to-back.
        g0 = gnt_cyc_log.size();
        d0 = done_cyc_log.size();
        data_in[15:8] = 8'h00;
        req = 4'b0010;
        wait_gnt(1, "t032_gnt1");
        tick();
        data_in[15:8] = 8'b1110_0000;
        wait_gnt(1, "t032_gnt2");
        tick();
        req = '0;
        wait_idle("t032_idle");
        check("t032_grants", gnt_cyc_log.size(), g0 + 2);
        check("t032_dones", done_cyc_log.size(), d0 + 2);
        if (gnt_cyc_log.size() >= g0 + 2 && done_cnt_log.size() >= d0 + 2) begin
            check("t032_spacing", gnt_cyc_log[g0+1] - gnt_cyc_log[g0], 10);
            check("t032_count1", done_cnt_log[d0], 0);
            check("t032_count2", done_cnt_log[d0+1], 0);
        end

        // Reset mid-byte on requester 2, then requester 0 must win.
        data_in[23:16] = 8'b0111_1111;
        req = 4'b0100;
        wait_gnt(2, "t034_gnt");
        d0 = done_cyc_log.size();
        repeat (4) tick();
        reset = 1'b1;
        req   = '0;
        repeat (2) tick();
        check("t034_no_done", done_cyc_log.size(), d0);
        for (int k = 0; k < NREQ; k++) data_in[8*k +: 8] = rand_byte();
        reset = 1'b0;
        req   = 4'b1011;
        t = 0;
        while (gnt == '0 && t < BUDGET) begin
            tick();
            t++;
        end
        check("t034_regrant", gnt, 4'b0001);
        tick();
        req = '0;
        wait_idle("t034_idle");
        check("t034_no_done_after", done_cyc_log.size(), d0 + 1);

        // Randomised traffic: requesters raise at random, refresh or drop after grant.
        last_g = '0;
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int k = 0; k < NREQ; k++) begin
                if (last_g[k]) begin
                    if ($urandom_range(1) == 0) data_in[8*k +: 8] = rand_byte();
                    else req[k] = 1'b0;
                end else if (!req[k] && $urandom_range(3) == 0) begin
                    data_in[8*k +: 8] = rand_byte();
                    req[k] = 1'b1;
                end
            end
            last_g = gnt;
        end
        t = 0;
        while (req != '0 && t < BUDGET * 8) begin
            tick();
            t++;
            for (int k = 0; k < NREQ; k++)
                if (last_g[k]) req[k] = 1'b0;
            last_g = gnt;
        end
        check("rand_drain", req, 0);
        wait_idle("rand_idle");

        // All-ones pattern instance with an all-ones byte.
        data_p[7:0] = 8'hFF;
        req_p = 4'b0001;
        t = 0;
        while (!gnt_p[0] && t < BUDGET) begin
            tick();
            t++;
        end
        check("t035_gnt", gnt_p[0], 1);
        tick();
        req_p = '0;
        t = 0;
        while (!done_p && t < BUDGET) begin
            tick();
            t++;
        end
        check("t035_done", done_p, 1);
        check("t035_id", done_id_p, 0);
        check("t035_count", mc_p, 5);
`ifdef SMS_HIT_MASK_EN
        check("t035_mask", hit_mask_p, 8'b1111_1000);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
